// File: rtl/down_count_checker.sv
// down_count_checker
//
// Purpose:
//   Watches the output bus of a free-running down-counter. The block samples
//   the bus on every enabled clock edge and checks that each sample is exactly
//   one less than the previous sample, with 0 wrapping to all-ones. It counts
//   valid wrap-arounds and sequence errors. After ERR_LIMIT consecutive errors
//   it latches a sticky fault.
//
// Ports:
//   clk        - single clock; all state changes on its rising edge
//   rst        - asynchronous active-high reset
//   en         - sample strobe; qIn is only looked at when en is high
//   clr        - synchronous clear back to IDLE; takes priority over en
//   qIn        - count value coming from the down-counter
//   locked     - high while the sequence is being tracked
//   fault      - sticky; high once the consecutive-error limit is reached
//   wrapPulse  - one cycle high after a valid 0 -> max step
//   errPulse   - one cycle high after a mismatch while tracking
//   wrapCount  - saturating count of wraps seen
//   errCount   - saturating count of mismatches seen
module down_count_checker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_W     = 4,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [WIDTH-1:0]  qIn,
  output logic              locked,
  output logic              fault,
  output logic              wrapPulse,
  output logic              errPulse,
  output logic [WRAP_W-1:0] wrapCount,
  output logic [ERR_W-1:0]  errCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  QONE      = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAPONE   = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ERRONE    = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERRLIMITV = ERR_W'(ERR_LIMIT);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [ERR_W-1:0]    consErr_q, consErr_d;
  logic [WRAP_W-1:0]   wrapCount_q, wrapCount_d;
  logic [ERR_W-1:0]    errCount_q, errCount_d;
  logic                wrapPulse_q, wrapPulse_d;
  logic                errPulse_q, errPulse_d;

  logic [WIDTH-1:0]    expVal;
  logic [ERR_W-1:0]    consErrInc;
  logic [WRAP_W-1:0]   wrapCountInc;
  logic [ERR_W-1:0]    errCountInc;

  // Expected next sample and the saturating increments. The subtraction is
  // kept at WIDTH bits so that 0 - 1 naturally becomes the all-ones value,
  // which is exactly the wrap the down-counter performs.
  always_comb begin
    expVal       = prev_q - QONE;
    consErrInc   = (consErr_q == '1)   ? consErr_q   : consErr_q + ERRONE;
    wrapCountInc = (wrapCount_q == '1) ? wrapCount_q : wrapCount_q + WRAPONE;
    errCountInc  = (errCount_q == '1)  ? errCount_q  : errCount_q + ERRONE;
  end

  // Next-state logic. Everything holds by default and the pulses drop, so an
  // idle (en low) cycle or a cycle in FAULT leaves only the pulses changing.
  // The wrap test looks at the previous sample (before it is overwritten): a
  // wrap is a matching step whose predecessor was 0.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    consErr_d   = consErr_q;
    wrapCount_d = wrapCount_q;
    errCount_d  = errCount_q;
    wrapPulse_d = 1'b0;
    errPulse_d  = 1'b0;

    if (clr) begin
      state_d     = IDLE;
      prev_d      = '0;
      consErr_d   = '0;
      wrapCount_d = '0;
      errCount_d  = '0;
    end else if (en) begin
      unique case (state_q)
        IDLE: begin
          prev_d  = qIn;
          state_d = SYNC;
        end
        SYNC: begin
          prev_d = qIn;
          if (qIn == expVal) begin
            state_d = TRACK;
          end
        end
        TRACK: begin
          prev_d = qIn;
          if (qIn == expVal) begin
            consErr_d = '0;
            if (prev_q == '0) begin
              wrapPulse_d = 1'b1;
              wrapCount_d = wrapCountInc;
            end
          end else begin
            errPulse_d = 1'b1;
            errCount_d = errCountInc;
            consErr_d  = consErrInc;
            if (consErrInc == ERRLIMITV) begin
              state_d = FAULT;
            end
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers. Reset is asynchronous so the outputs drop immediately,
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      consErr_q   <= '0;
      wrapCount_q <= '0;
      errCount_q  <= '0;
      wrapPulse_q <= 1'b0;
      errPulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      consErr_q   <= consErr_d;
      wrapCount_q <= wrapCount_d;
      errCount_q  <= errCount_d;
      wrapPulse_q <= wrapPulse_d;
      errPulse_q  <= errPulse_d;
    end
  end

  // Outputs come straight from registers (state decode only), so there is no
  // combinational path from any input to any output.
  always_comb begin
    locked    = (state_q == TRACK);
    fault     = (state_q == FAULT);
    wrapPulse = wrapPulse_q;
    errPulse  = errPulse_q;
    wrapCount = wrapCount_q;
    errCount  = errCount_q;
  end

endmodule

// File: tb/tb_down_count_checker.sv
// tb_down_count_checker
//
// Purpose:
//   Directed bench for down_count_checker. Each step drives inputs on the
//   falling edge, runs a small behavioural model of the checker to predict the
//   outputs after the next rising edge, queues that prediction, and then pops
//   and compares it just after the edge.
//
// Ports: none (top-level bench).
module tb_down_count_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [3:0] qIn;
  logic       locked;
  logic       fault;
  logic       wrapPulse;
  logic       errPulse;
  logic [7:0] wrapCount;
  logic [3:0] errCount;

  int errors = 0;
  int checks = 0;

  logic [15:0] expQ[$];

  int mState;
  int mPrev;
  int mCons;
  int mWrap;
  int mErr;
  bit mWp;
  bit mEp;

  down_count_checker #(
    .WIDTH(4),
    .WRAP_W(8),
    .ERR_W(4),
    .ERR_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .qIn(qIn),
    .locked(locked),
    .fault(fault),
    .wrapPulse(wrapPulse),
    .errPulse(errPulse),
    .wrapCount(wrapCount),
    .errCount(errCount)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model reset: every piece of checker state back to its power-on value.
  task automatic modelReset();
    mState = 0;
    mPrev  = 0;
    mCons  = 0;
    mWrap  = 0;
    mErr   = 0;
    mWp    = 1'b0;
    mEp    = 1'b0;
  endtask

  // Behavioural model of one rising edge. States: 0 idle, 1 sync, 2 track,
  // 3 fault. Expected sample is the previous one minus 1, modulo 16.
  task automatic modelStep(input bit e, input bit c, input int q);
    int expV;
    mWp  = 1'b0;
    mEp  = 1'b0;
    expV = (mPrev + 15) % 16;
    if (c) begin
      mState = 0;
      mPrev  = 0;
      mCons  = 0;
      mWrap  = 0;
      mErr   = 0;
    end else if (e) begin
      case (mState)
        0: begin
          mPrev  = q;
          mState = 1;
        end
        1: begin
          if (q == expV) mState = 2;
          mPrev = q;
        end
        2: begin
          if (q == expV) begin
            mCons = 0;
            if (mPrev == 0) begin
              mWp = 1'b1;
              if (mWrap < 255) mWrap = mWrap + 1;
            end
          end else begin
            mEp = 1'b1;
            if (mErr < 15) mErr = mErr + 1;
            if (mCons < 15) mCons = mCons + 1;
            if (mCons == 3) mState = 3;
          end
          mPrev = q;
        end
        default: begin
        end
      endcase
    end
  endtask

  function automatic logic [15:0] modelOut();
    return {mState == 2, mState == 3, mWp, mEp, 8'(mWrap), 4'(mErr)};
  endfunction

  // Pop the oldest prediction and compare it with the full output bundle
  // {locked, fault, wrapPulse, errPulse, wrapCount, errCount}.
  task automatic checkOutput(input string tag);
    logic [15:0] obs;
    logic [15:0] ex;
    obs = {locked, fault, wrapPulse, errPulse, wrapCount, errCount};
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      ex = expQ.pop_front();
      assert (obs === ex) else begin
        errors++;
        $error("[TB] FAIL %s: observed l=%b f=%b wp=%b ep=%b wc=%0d ec=%0d, expected l=%b f=%b wp=%b ep=%b wc=%0d ec=%0d",
               tag, obs[15], obs[14], obs[13], obs[12], obs[11:4], obs[3:0],
               ex[15], ex[14], ex[13], ex[12], ex[11:4], ex[3:0]);
      end
    end
  endtask

  // One enabled/disabled sample: drive on the falling edge, predict, then
  // check just after the rising edge.
  task automatic applyStimulus(input bit e, input bit c, input int q, input string tag);
    @(negedge clk);
    en  = e;
    clr = c;
    qIn = 4'(q);
    modelStep(e, c, q);
    expQ.push_back(modelOut());
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Directed sequence: lock, wrap, glitch recovery, fault, en gating, clear,
  // wrap-counter saturation and asynchronous reset mid-cycle.
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    qIn = 4'd0;
    modelReset();
    #12;
    expQ.push_back(modelOut());
    checkOutput("reset");
    #2;
    rst = 1'b0;

    applyStimulus(1, 0, 9, "lock_capture");
    applyStimulus(1, 0, 8, "lock_sync");
    applyStimulus(1, 0, 7, "lock_track");
    for (int v = 6; v >= 0; v--) applyStimulus(1, 0, v, "count_down");
    applyStimulus(1, 0, 15, "wrap");
    applyStimulus(1, 0, 14, "after_wrap");

    for (int v = 13; v >= 5; v--) applyStimulus(1, 0, v, "pre_glitch");
    applyStimulus(1, 0, 9, "glitch");
    applyStimulus(1, 0, 8, "glitch_recover");
    applyStimulus(1, 0, 7, "glitch_after");

    applyStimulus(1, 1, 0, "clr_before_fault");
    applyStimulus(1, 0, 5, "fault_capture");
    applyStimulus(1, 0, 4, "fault_sync");
    applyStimulus(1, 0, 3, "fault_match");
    applyStimulus(1, 0, 3, "fault_err1");
    applyStimulus(1, 0, 3, "fault_err2");
    applyStimulus(1, 0, 3, "fault_err3");
    applyStimulus(1, 0, 3, "fault_hold1");
    applyStimulus(1, 0, 2, "fault_hold2");
    applyStimulus(1, 0, 1, "fault_hold3");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, int'($urandom_range(0, 15)), "en_gated");
    end
    applyStimulus(1, 1, 7, "clr_with_en");
    applyStimulus(1, 0, 6, "post_clr_capture");

    applyStimulus(1, 1, 0, "clr_before_sat");
    for (int i = 0; i < 16 * 302; i++) begin
      applyStimulus(1, 0, 15 - (i % 16), "saturate");
    end

    #2;
    rst = 1'b1;
    #1;
    modelReset();
    expQ.push_back(modelOut());
    checkOutput("async_reset");
    #2;
    rst = 1'b0;
    applyStimulus(1, 0, 9, "rst_capture");
    applyStimulus(1, 0, 8, "rst_relock");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/down_count_checker.md
# down_count_checker

Downstream consumer of the 4-bit synchronous down-counter: samples the counter output every enabled cycle, verifies that each sample is exactly one less than the previous one (mod 2^WIDTH), counts wrap-arounds (0 → max), and counts sequence errors. After enough consecutive errors it latches a sticky fault. It sits directly on the counter's `qOut` bus in the lab top level and feeds status LEDs and gtkwave-visible flags.

## Interface
- `WIDTH`, 4: width of the monitored count bus.
- `WRAP_W`, 8: width of the wrap counter.
- `ERR_W`, 4: width of the error counter.
- `ERR_LIMIT`, 3: consecutive mismatches that force FAULT (1..2^ERR_W-1).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: sample strobe; `qIn` is evaluated only on edges with `en`=1.
- `clr` input 1: synchronous clear. Returns the block to IDLE and zeroes all counters and flags.
- `qIn` input WIDTH: count value from the down-counter.
- `locked` output 1: high while in TRACK.
- `fault` output 1: high while in FAULT (sticky).
- `wrapPulse` output 1: one-cycle pulse when a valid 0 → 2^WIDTH-1 step is seen.
- `errPulse` output 1: one-cycle pulse when a mismatch is seen in TRACK.
- `wrapCount` output WRAP_W: number of wraps seen, saturating.
- `errCount` output ERR_W: total mismatches seen, saturating.

## Operation
- Internal registers:
  - `prev` (WIDTH): last sampled value.
  - `consErr` (ERR_W): consecutive-mismatch count.
  - `state`: 2-bit FSM with states IDLE, SYNC, TRACK, FAULT.
- Expected value: `exp = prev - 1`, computed in WIDTH bits so that 0 - 1 = 2^WIDTH-1.
- IDLE, on `en`: capture `prev ← qIn` and go to SYNC.
- SYNC, on `en`:
  - If `qIn == exp`, go to TRACK.
  - Otherwise stay in SYNC.
  - In both cases, capture `prev ← qIn`.
  - No pulses and no counting in SYNC.
- TRACK, on `en`, capture `prev ← qIn` and then:
  - Match: clear `consErr`. If `prev == 0`, pulse `wrapPulse` and increment `wrapCount`.
  - Mismatch: pulse `errPulse`, increment `errCount`, and increment `consErr`.
  - If the incremented `consErr` equals ERR_LIMIT, go to FAULT.
- FAULT: ignore `en` and `qIn`. Hold all counters and `prev`. Leave only via `clr` or `rst`.
- `en`=0 in any state: hold all state. Pulses are low.
- Counters saturate at all-ones and never wrap.
- `clr` has priority over `en` on the same edge. After `clr`: state = IDLE, `wrapCount` = `errCount` = `consErr` = 0, pulses low.
- Reset values: state = IDLE, `prev` = 0, `consErr` = 0, `locked` = 0, `fault` = 0, `wrapPulse` = 0, `errPulse` = 0, `wrapCount` = 0, `errCount` = 0.
- Reset mid-operation returns the block to these values immediately, independent of `clk`. The first `en` edge after reset is a fresh IDLE capture.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency is 1 cycle: an event sampled at rising edge N is visible on the outputs just after edge N.
  - `wrapPulse` and `errPulse` are high for exactly the cycle following edge N.
  - They fall at edge N+1 unless a new event occurs at N+1.
  - Back-to-back events produce continuously high pulses.
- `locked` rises at the edge where SYNC→TRACK is taken. It falls at the edge entering FAULT, or at `clr`.
- `fault` rises on the same edge that `locked` falls due to the limit, and on the same edge as the final `errPulse`.
- Minimum lock time after reset is 2 enabled samples.
- Release of `rst` is asynchronous. The first sampling edge is the first rising `clk` edge with `rst`=0.

## Test plan
- Reset then lock: apply `rst`=1, release it, then feed `en`=1 with `qIn` = 9, 8, 7.
  - Required: `locked` high after the 2nd edge.
  - Required: `errCount` = 0 and `wrapCount` = 0.
- Wrap: while locked, feed 1, 0, 15, 14.
  - Required: exactly one `wrapPulse`, in the cycle after the 15 sample.
  - Required: `wrapCount` = 1 and no `errPulse`.
- Single glitch recovery: while locked, feed 6, 5, 9, 8.
  - The 9 produces an `errPulse` and `errCount` = 1.
  - The 8 matches (exp = 8) and clears `consErr`.
  - `locked` stays high throughout.
- Fault: while locked, feed 3, 3, 3, 3 with ERR_LIMIT = 3.
  - Required: three `errPulse` cycles and `errCount` = 3.
  - Required: `fault` = 1 and `locked` = 0 after the 4th sample.
  - Further samples change nothing.
- `en` gating and clear:
  - Deassert `en` for 5 cycles while `qIn` changes arbitrarily. Required: no state change.
  - Then assert `clr` together with `en`. Required: state IDLE, counters 0, and `fault` cleared on that edge.
- Saturation and async reset:
  - Drive 300 wraps with WRAP_W = 8. Required: `wrapCount` holds at 255.
  - Assert `rst` between clock edges. Required: all outputs go to 0 before the next edge.
